// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the input conditioner.
//   - default timing constants for a 50 MHz system clock
//   - repeat FSM state encoding
//   - clog2_max(): counter width needed to hold max(a, b)
package input_pkg;

  localparam int DEBOUNCE_10MS_50M      = 500000;
  localparam int REPEAT_DELAY_500MS_50M = 25000000;
  localparam int REPEAT_RATE_100MS_50M  = 5000000;

  typedef enum logic [1:0] {
    RPT_IDLE  = 2'd0,
    RPT_DELAY = 2'd1,
    RPT_RATE  = 2'd2
  } rpt_state_e;

  function automatic int clog2_max(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Pin-side and strobe-side bundle of the input conditioner.
//   noisy       : raw pin levels (asynchronous to clk)
//   clean       : debounced level, logical polarity (1 = active)
//   press       : one-cycle strobe on clean 0->1
//   release_stb : one-cycle strobe on clean 1->0
//   repeat_stb  : one-cycle auto-repeat strobe while clean is held
// master = pin/stimulus side, slave = conditioner side.
interface input_conditioner_if #(
  parameter int NUM_CH = 8
);
  logic [NUM_CH-1:0] noisy;
  logic [NUM_CH-1:0] clean;
  logic [NUM_CH-1:0] press;
  logic [NUM_CH-1:0] release_stb;
  logic [NUM_CH-1:0] repeat_stb;

  modport master (
    output noisy,
    input  clean, press, release_stb, repeat_stb
  );

  modport slave (
    input  noisy,
    output clean, press, release_stb, repeat_stb
  );
endinterface

// File: rtl/input_conditioner_channel.sv
// One conditioner channel: polarity fix, 2-flop synchroniser, debounce,
// press/release edge strobes and optional auto-repeat FSM.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   noisy        : raw pin level
//   clean        : debounced logical level
//   press        : strobe on clean rising
//   release_stb  : strobe on clean falling
//   repeat_stb   : auto-repeat strobe (only when REPEAT_BIT = 1)
module conditioner_channel
  import input_pkg::*;
#(
  parameter int   STABLE_CYCLES = DEBOUNCE_10MS_50M,
  parameter int   REPEAT_DELAY  = REPEAT_DELAY_500MS_50M,
  parameter int   REPEAT_RATE   = REPEAT_RATE_100MS_50M,
  parameter logic INVERT_BIT    = 1'b0,
  parameter logic REPEAT_BIT    = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic noisy,
  output logic clean,
  output logic press,
  output logic release_stb,
  output logic repeat_stb
);

  localparam int DB_W  = clog2_max(STABLE_CYCLES, 0);
  localparam int RPT_W = clog2_max(REPEAT_DELAY, REPEAT_RATE);

  logic             s1_q, s1_d, s2_q, s2_d;
  logic             clean_q, clean_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_q, repeat_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  rpt_state_e       state_q, state_d;

  always_comb begin
    // Inversion happens before the synchroniser so the reset value 0 of
    // both flops is the logical inactive level.
    s1_d = noisy ^ INVERT_BIT;
    s2_d = s1_q;

    clean_d  = clean_q;
    db_cnt_d = '0;
    if (s2_q != clean_q) begin
      if (db_cnt_q == DB_W'(STABLE_CYCLES - 1)) begin
        clean_d = s2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end

    press_d   = clean_d & ~clean_q;
    release_d = ~clean_d & clean_q;

    // The FSM reacts to the edge in the same cycle clean changes, so the
    // first repeat lands exactly REPEAT_DELAY cycles after the press strobe
    // and a release on the would-be repeat edge suppresses it.
    state_d   = state_q;
    rpt_cnt_d = rpt_cnt_q;
    repeat_d  = 1'b0;
    if (REPEAT_BIT) begin
      unique case (state_q)
        RPT_IDLE: begin
          if (press_d) begin
            state_d   = RPT_DELAY;
            rpt_cnt_d = '0;
          end
        end
        RPT_DELAY: begin
          if (release_d) begin
            state_d   = RPT_IDLE;
            rpt_cnt_d = '0;
          end else if (rpt_cnt_q == RPT_W'(REPEAT_DELAY - 1)) begin
            state_d   = RPT_RATE;
            rpt_cnt_d = '0;
            repeat_d  = 1'b1;
          end else begin
            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
          end
        end
        RPT_RATE: begin
          if (release_d) begin
            state_d   = RPT_IDLE;
            rpt_cnt_d = '0;
          end else if (rpt_cnt_q == RPT_W'(REPEAT_RATE - 1)) begin
            rpt_cnt_d = '0;
            repeat_d  = 1'b1;
          end else begin
            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
          end
        end
        default: begin
          state_d   = RPT_IDLE;
          rpt_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      clean_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      db_cnt_q  <= '0;
      rpt_cnt_q <= '0;
      state_q   <= RPT_IDLE;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      clean_q   <= clean_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      db_cnt_q  <= db_cnt_d;
      rpt_cnt_q <= rpt_cnt_d;
      state_q   <= state_d;
    end
  end

  assign clean       = clean_q;
  assign press       = press_q;
  assign release_stb = release_q;
  assign repeat_stb  = repeat_q;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel push-button / DIP-switch front end. Each of NUM_CH
// independent channels is synchronised, polarity-corrected, debounced and
// turned into a clean level plus press/release/repeat strobes.
// Ports:
//   clk     : system clock (clk_50)
//   reset_n : asynchronous active-low reset
//   bus     : input_conditioner_if slave (noisy in; clean/press/
//             release_stb/repeat_stb out)
module input_conditioner
  import input_pkg::*;
#(
  parameter int              NUM_CH        = 8,
  parameter int              STABLE_CYCLES = DEBOUNCE_10MS_50M,
  parameter logic [NUM_CH-1:0] INVERT      = '0,
  parameter logic [NUM_CH-1:0] REPEAT_EN   = '0,
  parameter int              REPEAT_DELAY  = REPEAT_DELAY_500MS_50M,
  parameter int              REPEAT_RATE   = REPEAT_RATE_100MS_50M
) (
  input  logic                clk,
  input  logic                reset_n,
  input_conditioner_if.slave  bus
);

  logic [NUM_CH-1:0] clean_w, press_w, release_w, repeat_w;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    conditioner_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_RATE   (REPEAT_RATE),
      .INVERT_BIT    (INVERT[g]),
      .REPEAT_BIT    (REPEAT_EN[g])
    ) u_ch (
      .clk         (clk),
      .reset_n     (reset_n),
      .noisy       (bus.noisy[g]),
      .clean       (clean_w[g]),
      .press       (press_w[g]),
      .release_stb (release_w[g]),
      .repeat_stb  (repeat_w[g])
    );
  end

  assign bus.clean       = clean_w;
  assign bus.press       = press_w;
  assign bus.release_stb = release_w;
  assign bus.repeat_stb  = repeat_w;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner (4 channels, short timing).
// A reference model built from the behavioural rules (sample delay line,
// run-length debounce, time-since-press repeat schedule) pushes the
// expected outputs of every clock edge into a queue; a monitor pops and
// compares after each edge.
module tb_input_conditioner;

  localparam int          NUM_CH = 4;
  localparam int          STABLE = 4;
  localparam int          RD     = 10;
  localparam int          RR     = 3;
  localparam logic [3:0]  INV    = 4'b0010;
  localparam logic [3:0]  REN    = 4'b0001;
  localparam logic [3:0]  IDLE_PINS = 4'b0010;

  typedef struct {
    logic [3:0] clean;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] rpt;
  } exp_t;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t exp_q[$];

  input_conditioner_if #(.NUM_CH(NUM_CH)) bus ();

  input_conditioner #(
    .NUM_CH        (NUM_CH),
    .STABLE_CYCLES (STABLE),
    .INVERT        (INV),
    .REPEAT_EN     (REN),
    .REPEAT_DELAY  (RD),
    .REPEAT_RATE   (RR)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, got, want);
    end
  endtask

  // Reference model: logical pin value reaches the debouncer two edges
  // after it is sampled; clean flips once the disagreement has lasted
  // STABLE consecutive edges; repeats fire RD, RD+RR, RD+2RR... edges
  // after the press edge while the channel is still held.
  bit prev1 [NUM_CH];
  bit prev2 [NUM_CH];
  bit clean_m [NUM_CH];
  int run [NUM_CH];
  int since [NUM_CH];

  initial begin
    exp_t e;
    bit   lin, seen, old_c, pr, rl, rp;
    for (int c = 0; c < NUM_CH; c++) begin
      prev1[c] = 0; prev2[c] = 0; clean_m[c] = 0; run[c] = 0; since[c] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      e.clean = '0; e.press = '0; e.rel = '0; e.rpt = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (!reset_n) begin
          prev1[c] = 0; prev2[c] = 0; clean_m[c] = 0; run[c] = 0; since[c] = 0;
        end else begin
          lin      = bus.noisy[c] ^ INV[c];
          seen     = prev2[c];
          prev2[c] = prev1[c];
          prev1[c] = lin;
          old_c    = clean_m[c];
          if (seen != old_c) begin
            run[c]++;
            if (run[c] == STABLE) begin
              clean_m[c] = seen;
              run[c]     = 0;
            end
          end else begin
            run[c] = 0;
          end
          pr = clean_m[c] && !old_c;
          rl = !clean_m[c] && old_c;
          if (pr) since[c] = 0;
          else if (clean_m[c]) since[c]++;
          rp = REN[c] && clean_m[c] && !pr && (since[c] >= RD) && (((since[c] - RD) % RR) == 0);
          e.clean[c] = clean_m[c];
          e.press[c] = pr;
          e.rel[c]   = rl;
          e.rpt[c]   = rp;
        end
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: compare the DUT outputs of each edge against the model.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("clean",   bus.clean,       e.clean);
        chk("press",   bus.press,       e.press);
        chk("release", bus.release_stb, e.rel);
        chk("repeat",  bus.repeat_stb,  e.rpt);
      end
    end
  end

  task automatic hold(input logic [3:0] pins, input int cycles);
    @(negedge clk);
    bus.noisy = pins;
    repeat (cycles) @(posedge clk);
  endtask

  task automatic pulse_reset(input int low_cycles);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_clean",   bus.clean,       4'b0000);
    chk("rst_press",   bus.press,       4'b0000);
    chk("rst_release", bus.release_stb, 4'b0000);
    chk("rst_repeat",  bus.repeat_stb,  4'b0000);
    repeat (low_cycles) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [3:0] v;
    reset_n   = 1'b0;
    bus.noisy = IDLE_PINS;
    #2;
    chk("init_clean",   bus.clean,       4'b0000);
    chk("init_press",   bus.press,       4'b0000);
    chk("init_release", bus.release_stb, 4'b0000);
    chk("init_repeat",  bus.repeat_stb,  4'b0000);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // ch0 held: press, repeats, then release
    hold(4'b0011, 30);
    hold(IDLE_PINS, 12);
    // ch2 bounce, then long hold without repeat
    hold(4'b0110, 3);
    hold(IDLE_PINS, 10);
    hold(4'b0110, 50);
    hold(IDLE_PINS, 10);
    // ch1 active-low pin pulled low
    hold(4'b0000, 12);
    hold(IDLE_PINS, 12);
    // ch0 released on the edge the first repeat would fire
    hold(4'b0011, 10);
    hold(IDLE_PINS, 12);
    // reset mid-debounce, input still high afterwards
    hold(4'b0011, 4);
    pulse_reset(2);
    hold(4'b0011, 12);
    hold(IDLE_PINS, 10);
    // reset mid-RATE
    hold(4'b0011, 20);
    pulse_reset(2);
    hold(4'b0011, 12);
    hold(IDLE_PINS, 10);

    // Random multi-channel traffic with sticky levels and rare resets
    v = IDLE_PINS;
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < NUM_CH; c++)
        if ($urandom_range(5) == 0) v[c] = ~v[c];
      if ($urandom_range(299) == 0) pulse_reset(1 + $urandom_range(2));
      hold(v, 1);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
